seq_det_moore_param: RTL and testbench



---
 rtl/seq_det_pkg.sv | 36 +++
 rtl/seq_det_sat_cnt.sv | 22 ++
 rtl/seq_det_moore_param.sv | 74 +++++++
 tb/tb_seq_det_moore_param.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and elaboration-time helpers for the parametrised Moore sequence detector
package seq_det_pkg;

  localparam int S0_IDX = 0;

  // Binary state width that holds S0..S_PAT_W
  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // KMP-style successor of state k after consuming din. Pattern bit pat_w-1 is received first.
  // Leaving the full-match state without overlap restarts from S0 before din is consumed.
  function automatic int next_state(input int pat_w, input logic [15:0] pattern,
                                    input int k, input logic din, input logic overlap);
    int unsigned pat;
    int unsigned seqv;
    int unsigned mask;
    int          cur;
    int          maxl;
    int          res;
    pat  = 32'(pattern);
    cur  = (k == pat_w && !overlap) ? 0 : k;
    // Consumed history: first cur pattern bits followed by din, newest bit in the LSB
    seqv = ((pat >> (pat_w - cur)) << 1) | 32'(din);
    maxl = (cur + 1 > pat_w) ? pat_w : cur + 1;
    res  = 0;
    for (int l = 1; l <= 16; l++) begin
      if (l <= maxl) begin
        mask = (32'd1 << l) - 32'd1;
        if ((seqv & mask) == (pat >> (pat_w - l))) res = l;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// rtl/seq_det_sat_cnt.sv - saturating up-counter with synchronous clear
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Clear wins; otherwise count up and stick at all-ones
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_moore_param.sv
// rtl/seq_det_moore_param.sv - parametrised Moore sequence detector; SEQ_DET_MATCH_CNT_EN enables the match counter
module seq_det_moore_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int            SW = state_w(PAT_W);
  localparam logic [SW-1:0] S0 = SW'(S0_IDX);
  localparam logic [SW-1:0] SF = SW'(PAT_W);

  logic [SW-1:0] ns_tab [PAT_W+1][2][2];
  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic          legal;

  // Next-state table fixed at elaboration, indexed by [state][din][overlap]
  for (genvar k = 0; k <= PAT_W; k++) begin : g_state
    for (genvar d = 0; d < 2; d++) begin : g_din
      for (genvar o = 0; o < 2; o++) begin : g_ovl
        localparam int NS = next_state(PAT_W, 16'(PATTERN), k, 1'(d), 1'(o));
        assign ns_tab[k][d][o] = SW'(NS);
      end
    end
  end

  assign legal = (state <= SF);

  // Table lookup when a bit is consumed; hold otherwise; unused codes fall back to S0
  always_comb begin
    state_nxt = S0;
    if (legal) begin
      state_nxt = din_valid ? ns_tab[state][din][overlap] : state;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  assign dout = (state == SF);

`ifdef SEQ_DET_MATCH_CNT_EN
  logic enter_match;

  // Every consuming edge that lands in the full-match state counts, including re-entry
  assign enter_match = legal && din_valid && (ns_tab[state][din][overlap] == SF);

  seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .clr (reset),
    .inc (enter_match),
    .cnt (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_moore_param.sv
// tb/tb_seq_det_moore_param.sv - table-driven bench for seq_det_moore_param (three parameter sets)
module tb_seq_det_moore_param;

`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    int dut;
    bit rst;
    bit din;
    bit vld;
    bit ovl;
    bit exp_d;
    int exp_c;
  } vec_t;

  logic       clk = 1'b0;
  logic [2:0] rst_v = '0;
  logic [2:0] din_v = '0;
  logic [2:0] vld_v = '0;
  logic [2:0] ovl_v = '0;
  logic [2:0] dout_v;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic [1:0] cnt_c;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_det_moore_param u_a (
    .clk(clk), .reset(rst_v[0]), .din(din_v[0]), .din_valid(vld_v[0]), .overlap(ovl_v[0]),
    .dout(dout_v[0]), .match_cnt(cnt_a)
  );

  seq_det_moore_param #(.PAT_W(5), .PATTERN(5'b10110), .CNT_W(8)) u_b (
    .clk(clk), .reset(rst_v[1]), .din(din_v[1]), .din_valid(vld_v[1]), .overlap(ovl_v[1]),
    .dout(dout_v[1]), .match_cnt(cnt_b)
  );

  seq_det_moore_param #(.PAT_W(4), .PATTERN(4'b1001), .CNT_W(2)) u_c (
    .clk(clk), .reset(rst_v[2]), .din(din_v[2]), .din_valid(vld_v[2]), .overlap(ovl_v[2]),
    .dout(dout_v[2]), .match_cnt(cnt_c)
  );

  task automatic v(input int dut, input bit rst, input bit din, input bit vld,
                   input bit ovl, input bit exp_d, input int exp_c);
    vec_t r;
    r.dut = dut; r.rst = rst; r.din = din; r.vld = vld;
    r.ovl = ovl; r.exp_d = exp_d; r.exp_c = exp_c;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input int dut, input bit rst, input bit din, input bit vld, input bit ovl);
    rst_v = '0;
    vld_v = '0;
    rst_v[dut] = rst;
    din_v[dut] = din;
    vld_v[dut] = vld;
    ovl_v[dut] = ovl;
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_of(input int dut);
    case (dut)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  initial begin
    logic [15:0] stream;
    logic [3:0]  win;
    int          m;
    bit          exp_d;

    // DUT A (1001): reset state
    v(0,1,0,0,1, 0,0);
    // overlapping stream 1001001
    v(0,0,1,1,1, 0,0); v(0,0,0,1,1, 0,0); v(0,0,0,1,1, 0,0); v(0,0,1,1,1, 1,1);
    v(0,0,0,1,1, 0,1); v(0,0,0,1,1, 0,1); v(0,0,1,1,1, 1,2);
    // non-overlapping stream 1001001
    v(0,1,0,0,0, 0,0);
    v(0,0,1,1,0, 0,0); v(0,0,0,1,0, 0,0); v(0,0,0,1,0, 0,0); v(0,0,1,1,0, 1,1);
    v(0,0,0,1,0, 0,1); v(0,0,0,1,0, 0,1); v(0,0,1,1,0, 0,1);
    // match held through invalid cycles, falls on next valid 0
    v(0,1,0,0,1, 0,0);
    v(0,0,1,1,1, 0,0); v(0,0,0,1,1, 0,0); v(0,0,0,1,1, 0,0); v(0,0,1,1,1, 1,1);
    v(0,0,1,0,1, 1,1); v(0,0,0,0,1, 1,1); v(0,0,1,0,1, 1,1); v(0,0,0,1,1, 0,1);
    // mid-sequence reset beats din_valid, then resume from S1
    v(0,1,0,0,1, 0,0);
    v(0,0,1,1,1, 0,0); v(0,0,0,1,1, 0,0); v(0,0,0,1,1, 0,0);
    v(0,1,1,1,1, 0,0);
    v(0,0,1,1,1, 0,0); v(0,0,0,1,1, 0,0); v(0,0,0,1,1, 0,0); v(0,0,1,1,1, 1,1);
    // reset while dout=1
    v(0,1,1,1,1, 0,0);
    // mode switch to overlap takes effect on the bit after a non-overlap match
    v(0,0,1,1,0, 0,0); v(0,0,0,1,0, 0,0); v(0,0,0,1,0, 0,0); v(0,0,1,1,0, 1,1);
    v(0,0,0,1,1, 0,1); v(0,0,0,1,1, 0,1); v(0,0,1,1,1, 1,2);

    // DUT B (10110, overlap): 10110110
    v(1,1,0,0,1, 0,0);
    v(1,0,1,1,1, 0,0); v(1,0,0,1,1, 0,0); v(1,0,1,1,1, 0,0); v(1,0,1,1,1, 0,0);
    v(1,0,0,1,1, 1,1); v(1,0,1,1,1, 0,1); v(1,0,1,1,1, 0,1); v(1,0,0,1,1, 1,2);
    // 1010110: the 0 after 101 falls back to S2, not S0
    v(1,1,0,0,1, 0,0);
    v(1,0,1,1,1, 0,0); v(1,0,0,1,1, 0,0); v(1,0,1,1,1, 0,0); v(1,0,0,1,1, 0,0);
    v(1,0,1,1,1, 0,0); v(1,0,1,1,1, 0,0); v(1,0,0,1,1, 1,1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].dut, vecs[i].rst, vecs[i].din, vecs[i].vld, vecs[i].ovl);
      check("dout", i, int'(dout_v[vecs[i].dut]), int'(vecs[i].exp_d));
      check("match_cnt", i, cnt_of(vecs[i].dut), CNT_EN ? vecs[i].exp_c : 0);
    end

    // DUT C (CNT_W=2): five overlapping matches, counter saturates at 3
    drive(2, 1'b1, 1'b0, 1'b0, 1'b1);
    check("c_reset_dout", 0, int'(dout_v[2]), 0);
    check("c_reset_cnt", 0, int'(cnt_c), 0);
    stream = 16'b1001001001001001;
    win = '0;
    m = 0;
    for (int i = 0; i < 16; i++) begin
      drive(2, 1'b0, stream[15-i], 1'b1, 1'b1);
      win = {win[2:0], stream[15-i]};
      exp_d = (i >= 3) && (win == 4'b1001);
      if (exp_d && m < 3) m++;
      check("c_dout", i, int'(dout_v[2]), int'(exp_d));
      check("c_cnt", i, int'(cnt_c), CNT_EN ? m : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
